// File: rtl/dram_rascas_ctrl_pkg.sv
// rtl/dram_rascas_ctrl_pkg.sv - state encoding and address field positions for dram_rascas_ctrl
package dram_rascas_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RAS,
        ST_CAS,
        ST_CAS2,
        ST_PRE,
        ST_RF_CAS,
        ST_RF_RAS,
        ST_RF_HOLD,
        ST_RF_PRE
    } state_t;

    localparam int BANK_BIT = 20;
    localparam int ROW_MSB  = 19;
    localparam int ROW_LSB  = 10;
    localparam int COL_MSB  = 9;
    localparam int COL_LSB  = 0;

    function automatic logic [9:0] addr_row(input logic [20:0] a);
        return a[ROW_MSB:ROW_LSB];
    endfunction

    function automatic logic [9:0] addr_col(input logic [20:0] a);
        return a[COL_MSB:COL_LSB];
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// rtl/dram_refresh_timer.sv - free-running down counter producing one refresh tick every REFRESH_PERIOD cycles
module dram_refresh_timer #(
    parameter int REFRESH_PERIOD = 434
) (
    input  logic fclk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = $clog2(REFRESH_PERIOD);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/dram_rascas_ctrl.sv
// rtl/dram_rascas_ctrl.sv - RAS/CAS/WE sequencer with CBR refresh for two-bank async DRAM; DRAM_CBR_REFRESH_EN enables the internal refresh timer
module dram_rascas_ctrl
    import dram_rascas_ctrl_pkg::*;
#(
    parameter int REFRESH_PERIOD = 434
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rnw,
    input  logic [20:0] addr,
    input  logic [1:0]  bsel,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        rdata_vld,
    output logic        busy,
    input  logic        rfsh_req,
    output logic [9:0]  ra,
    inout  wire  [15:0] rd,
    output logic        rwe_n,
    output logic        rucas_n,
    output logic        rlcas_n,
    output logic        rras0_n,
    output logic        rras1_n
);

    state_t      state;
    logic        q_rnw;
    logic [1:0]  q_bsel;
    logic [9:0]  q_col;
    logic [15:0] q_wdata;
    logic        rd_oe;
    logic        rfsh_pend;
    logic        rfsh_any;

`ifdef DRAM_CBR_REFRESH_EN
    logic tick;

    dram_refresh_timer #(
        .REFRESH_PERIOD(REFRESH_PERIOD)
    ) u_refresh_timer (
        .fclk  (fclk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign rfsh_any = rfsh_pend | rfsh_req | tick;
`else
    logic unused_period;
    assign unused_period = (REFRESH_PERIOD != 0);
    assign rfsh_any = rfsh_pend | rfsh_req;
`endif

    assign rd = rd_oe ? q_wdata : 16'hzzzz;

    // Every output is registered: values assigned on an edge are what the DRAM sees in the next state.
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ack       <= 1'b0;
            rdata     <= '0;
            rdata_vld <= 1'b0;
            busy      <= 1'b0;
            ra        <= '0;
            rd_oe     <= 1'b0;
            rwe_n     <= 1'b1;
            rucas_n   <= 1'b1;
            rlcas_n   <= 1'b1;
            rras0_n   <= 1'b1;
            rras1_n   <= 1'b1;
            rfsh_pend <= 1'b0;
            q_rnw     <= 1'b1;
            q_bsel    <= '0;
            q_col     <= '0;
            q_wdata   <= '0;
        end else begin
            ack       <= 1'b0;
            rdata_vld <= 1'b0;
            rfsh_pend <= rfsh_any;
            case (state)
                ST_IDLE: begin
                    if (rfsh_any) begin
                        state     <= ST_RF_CAS;
                        rfsh_pend <= 1'b0;
                        busy      <= 1'b1;
                        rucas_n   <= 1'b0;
                        rlcas_n   <= 1'b0;
                    end else if (req) begin
                        state   <= ST_RAS;
                        q_rnw   <= rnw;
                        q_bsel  <= bsel;
                        q_col   <= addr_col(addr);
                        q_wdata <= wdata;
                        ra      <= addr_row(addr);
                        rras0_n <= addr[BANK_BIT];
                        rras1_n <= ~addr[BANK_BIT];
                        rwe_n   <= rnw;
                        rd_oe   <= ~rnw;
                        ack     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_RAS: begin
                    state   <= ST_CAS;
                    ra      <= q_col;
                    rucas_n <= ~(q_rnw | q_bsel[1]);
                    rlcas_n <= ~(q_rnw | q_bsel[0]);
                end
                ST_CAS: state <= ST_CAS2;
                ST_CAS2: begin
                    state   <= ST_PRE;
                    rras0_n <= 1'b1;
                    rras1_n <= 1'b1;
                    rucas_n <= 1'b1;
                    rlcas_n <= 1'b1;
                    rwe_n   <= 1'b1;
                    rd_oe   <= 1'b0;
                    if (q_rnw) begin
                        rdata     <= rd;
                        rdata_vld <= 1'b1;
                    end
                end
                ST_PRE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_RF_CAS: begin
                    state   <= ST_RF_RAS;
                    rras0_n <= 1'b0;
                    rras1_n <= 1'b0;
                end
                ST_RF_RAS: state <= ST_RF_HOLD;
                ST_RF_HOLD: begin
                    state   <= ST_RF_PRE;
                    rras0_n <= 1'b1;
                    rras1_n <= 1'b1;
                    rucas_n <= 1'b1;
                    rlcas_n <= 1'b1;
                end
                ST_RF_PRE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_rascas_ctrl.sv
// tb/tb_dram_rascas_ctrl.sv - bench for dram_rascas_ctrl with DRAM model, per-cycle expectation queue and data scoreboard
module tb_dram_rascas_ctrl;

    localparam int PERIOD = 16;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        rnw = 1'b1;
    logic        rfsh_req = 1'b0;
    logic [20:0] addr = '0;
    logic [1:0]  bsel = '0;
    logic [15:0] wdata = '0;
    logic        ack, rdata_vld, busy, rwe_n, rucas_n, rlcas_n, rras0_n, rras1_n;
    logic [15:0] rdata;
    logic [9:0]  ra;
    wire  [15:0] rd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_cyc = 0;
    bit rfsh_rand = 1'b0;

    dram_rascas_ctrl #(.REFRESH_PERIOD(PERIOD)) dut (
        .fclk(fclk), .rst_n(rst_n), .req(req), .rnw(rnw), .addr(addr), .bsel(bsel),
        .wdata(wdata), .ack(ack), .rdata(rdata), .rdata_vld(rdata_vld), .busy(busy),
        .rfsh_req(rfsh_req), .ra(ra), .rd(rd), .rwe_n(rwe_n), .rucas_n(rucas_n),
        .rlcas_n(rlcas_n), .rras0_n(rras0_n), .rras1_n(rras1_n)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req_v, cyc);
        end
    endtask

    // DRAM chip model: latches row on RAS fall, column on CAS fall, writes enabled bytes, drives reads
    logic [15:0] dram [int];
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = '0;
    logic        p_r0 = 1'b1, p_r1 = 1'b1, p_u = 1'b1, p_l = 1'b1;
    logic [9:0]  row_l = '0, col_l = '0;
    logic        bank_l = 1'b0;
    int          b0_cnt = 0, b1_cnt = 0, rf_cnt = 0;

    assign rd = drv_en ? drv_val : 16'hzzzz;

    always @(negedge fclk) begin : dram_model
        int key;
        logic [15:0] old;
        if ((p_r0 && !rras0_n) || (p_r1 && !rras1_n)) begin
            row_l  = ra;
            bank_l = !rras1_n;
        end
        if (((p_u && !rucas_n) || (p_l && !rlcas_n)) && (!rras0_n || !rras1_n)) begin
            col_l = ra;
            if (!rwe_n) begin
                key = int'({bank_l, row_l, col_l});
                old = dram.exists(key) ? dram[key] : 16'h0;
                if (p_u && !rucas_n) old[15:8] = rd[15:8];
                if (p_l && !rlcas_n) old[7:0]  = rd[7:0];
                dram[key] = old;
            end
        end
        drv_en = (!rras0_n || !rras1_n) && (!rucas_n || !rlcas_n) && rwe_n;
        key = int'({bank_l, row_l, col_l});
        drv_val = dram.exists(key) ? dram[key] : 16'h0;
        if (!rras0_n && rras1_n) b0_cnt++;
        if (!rras1_n && rras0_n) b1_cnt++;
        if (!rucas_n && !rlcas_n && rras0_n && rras1_n) rf_cnt++;
        p_r0 = rras0_n; p_r1 = rras1_n; p_u = rucas_n; p_l = rlcas_n;
    end

    // Reference: each accepted operation expands into a fixed list of expected output cycles.
    // ctl = {ack, rdata_vld, busy, rras1_n, rras0_n, rucas_n, rlcas_n, rwe_n}
    typedef struct packed {
        logic [7:0]  ctl;
        logic [9:0]  ra;
        logic        wchk;
        logic [15:0] wd;
        logic        rchk;
        logic [15:0] rdv;
    } vec_t;

    function automatic vec_t mkv(input logic [7:0] c, input logic [9:0] a, input logic wc,
                                 input logic [15:0] wd, input logic rc, input logic [15:0] rv);
        vec_t v;
        v.ctl = c; v.ra = a; v.wchk = wc; v.wd = wd; v.rchk = rc; v.rdv = rv;
        return v;
    endfunction

    vec_t        exp_q[$];
    vec_t        cur;
    logic [15:0] ref_mem [int];
    logic        pend = 1'b0;
    int          tmr = PERIOD - 1;
    logic [9:0]  last_ra = '0;
    bit          model_on = 1'b0;

    always @(posedge fclk) begin : model
        logic tick, any, bk, r, cu, cl;
        logic [9:0] row, col;
        logic [15:0] old;
        int key;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            pend = 1'b0;
            tmr = PERIOD - 1;
            last_ra = '0;
            cur = mkv(8'b0001_1111, 10'd0, 1'b0, 16'h0, 1'b0, 16'h0);
            model_on = 1'b1;
        end else begin
            tick = 1'b0;
`ifdef DRAM_CBR_REFRESH_EN
            tick = (tmr == 0);
            tmr = tick ? PERIOD - 1 : tmr - 1;
`endif
            any = pend | rfsh_req | tick;
            if (exp_q.size() == 0 && any) begin
                pend = 1'b0;
                exp_q.push_back(mkv(8'b0011_1001, last_ra, 1'b0, 16'h0, 1'b0, 16'h0));
                exp_q.push_back(mkv(8'b0010_0001, last_ra, 1'b0, 16'h0, 1'b0, 16'h0));
                exp_q.push_back(mkv(8'b0010_0001, last_ra, 1'b0, 16'h0, 1'b0, 16'h0));
                exp_q.push_back(mkv(8'b0011_1111, last_ra, 1'b0, 16'h0, 1'b0, 16'h0));
                exp_q.push_back(mkv(8'b0001_1111, last_ra, 1'b0, 16'h0, 1'b0, 16'h0));
            end else begin
                if (exp_q.size() == 0 && req) begin
                    bk = addr[20]; r = rnw; row = addr[19:10]; col = addr[9:0];
                    key = int'(addr);
                    old = ref_mem.exists(key) ? ref_mem[key] : 16'h0;
                    cu = r ? 1'b0 : !bsel[1];
                    cl = r ? 1'b0 : !bsel[0];
                    exp_q.push_back(mkv({3'b101, !bk, bk, 2'b11, r}, row, !r, wdata, 1'b0, 16'h0));
                    exp_q.push_back(mkv({3'b001, !bk, bk, cu, cl, r}, col, !r, wdata, 1'b0, 16'h0));
                    exp_q.push_back(mkv({3'b001, !bk, bk, cu, cl, r}, col, !r, wdata, 1'b0, 16'h0));
                    exp_q.push_back(mkv({1'b0, r, 6'b11_1111}, col, 1'b0, 16'h0, r, old));
                    exp_q.push_back(mkv(8'b0001_1111, col, 1'b0, 16'h0, 1'b0, 16'h0));
                    if (!r) begin
                        if (bsel[1]) old[15:8] = wdata[15:8];
                        if (bsel[0]) old[7:0]  = wdata[7:0];
                        ref_mem[key] = old;
                    end
                    last_ra = col;
                end
                pend = any;
            end
            cur = (exp_q.size() != 0) ? exp_q.pop_front()
                                      : mkv(8'b0001_1111, last_ra, 1'b0, 16'h0, 1'b0, 16'h0);
        end
    end

    always @(negedge fclk) begin : compare
        if (model_on) begin
            chk("outputs", 32'({ack, rdata_vld, busy, rras1_n, rras0_n, rucas_n, rlcas_n, rwe_n, ra}),
                32'({cur.ctl, cur.ra}));
            if (cur.wchk) chk("rd_write_data", 32'(rd), 32'(cur.wd));
            if (cur.rchk) chk("rdata", 32'(rdata), 32'(cur.rdv));
        end
    end

    task automatic step();
        @(posedge fclk);
        #1;
        rfsh_req = rfsh_rand && ($urandom_range(0, 11) == 0);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_op(input logic r, input logic [20:0] a, input logic [1:0] s, input logic [15:0] d);
        bit got;
        got = 1'b0;
        req = 1'b1; rnw = r; addr = a; bsel = s; wdata = d;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge fclk);
            if (ack) begin
                got = 1'b1;
                ack_cyc = cyc;
            end
            step();
        end
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic read_expect(input logic [20:0] a, input logic [15:0] v, input string nm);
        bit got;
        got = 1'b0;
        do_op(1'b1, a, 2'b11, 16'h0);
        req = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge fclk);
            if (rdata_vld) begin
                got = 1'b1;
                chk(nm, 32'(rdata), 32'(v));
            end
        end
        chk({nm, "_vld"}, 32'(got), 32'd1);
        step();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        int b0s, b1s, rfs, c0;
        logic [20:0] pool [8];
        rst_n = 1'b0;
        repeat (3) @(posedge fclk);
        #1;
        rst_n = 1'b1;
        @(negedge fclk);
        chk("reset_strobes", 32'({rras1_n, rras0_n, rucas_n, rlcas_n, rwe_n}), 32'b11111);
        chk("reset_ra", 32'(ra), 32'd0);
        chk("reset_flags", 32'({ack, rdata_vld, busy}), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        step();

        do_op(1'b0, 21'h00123, 2'b11, 16'hA55A);
        idle(1);
        read_expect(21'h00123, 16'hA55A, "t1_read");

        do_op(1'b0, 21'h0A5C3, 2'b11, 16'h1234);
        do_op(1'b0, 21'h0A5C3, 2'b01, 16'hFF00);
        idle(0);
        read_expect(21'h0A5C3, 16'h1200, "t2_bytemask_read");
        do_op(1'b0, 21'h0A5C3, 2'b00, 16'hFFFF);
        idle(0);
        read_expect(21'h0A5C3, 16'h1200, "bsel00_read");

        b0s = b0_cnt; b1s = b1_cnt;
        do_op(1'b0, 21'h1F0F0F, 2'b11, 16'hC3C3);
        idle(0);
        read_expect(21'h1F0F0F, 16'hC3C3, "t3_bank1_read");
        chk("t3_ras0_cycles", 32'(b0_cnt - b0s), 32'd0);
        chk("t3_ras1_cycles", 32'(b1_cnt - b1s), 32'd6);

`ifndef DRAM_CBR_REFRESH_EN
        idle(3);
        rfs = rf_cnt;
        c0 = cyc;
        rfsh_req = 1'b1;
        do_op(1'b0, 21'h00456, 2'b11, 16'h7E7E);
        idle(0);
        chk("t4_ack_latency", 32'(ack_cyc - c0), 32'd6);
        chk("t4_refresh_count", 32'(rf_cnt - rfs), 32'd1);
        idle(2);
`endif

        for (int i = 0; i < 8; i++) pool[i] = 21'($urandom);
        rfsh_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            do_op(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                  2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
        end
        rfsh_rand = 1'b0;
        idle(20);

        rfs = rf_cnt;
        idle(64);
`ifdef DRAM_CBR_REFRESH_EN
        chk("t5_refresh_count", 32'(rf_cnt - rfs), 32'd4);
`else
        chk("t5_refresh_count", 32'(rf_cnt - rfs), 32'd0);
`endif

        do_op(1'b0, 21'h00777, 2'b11, 16'hBEEF);
        rst_n = 1'b0;
        req = 1'b0;
        @(posedge fclk);
        #1;
        rst_n = 1'b1;
        @(negedge fclk);
        chk("t6_strobes_after_reset", 32'({rras1_n, rras0_n, rucas_n, rlcas_n, rwe_n}), 32'b11111);
        chk("t6_flags_after_reset", 32'({ack, rdata_vld, busy}), 32'd0);
        step();
        idle(4);
        do_op(1'b0, 21'h00888, 2'b11, 16'h5AA5);
        idle(0);
        read_expect(21'h00888, 16'h5AA5, "t6_read_after_reset");

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
